// File: rtl/pc_pkg.sv
// Shared control-word bit positions and PC source selection for the program counter.
package pc_pkg;

  localparam int unsigned CS_PC_TO_MBR = 1;
  localparam int unsigned CS_PC_TO_MAR = 2;
  localparam int unsigned CS_MBR_TO_PC = 3;
  localparam int unsigned CS_PC_INC    = 20;
  localparam int unsigned CS_PC_BR     = 21;
  localparam int unsigned CS_CALL      = 22;
  localparam int unsigned CS_RET       = 23;
  localparam int unsigned CS_CLR_ERR   = 24;

  // Winning PC-update request after priority resolution.
  typedef enum logic [2:0] {
    PC_HOLD,
    PC_RET,
    PC_CALL,
    PC_LOAD,
    PC_BR,
    PC_INC
  } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: push/pop with full/empty guarding and a per-cycle error pulse.
module ras_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0]   SP_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   SP_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] IDX_ONE = PW'(1);

  logic [PW:0]      sp_q, sp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    top_idx;
  logic             do_push, do_pop;

  always_comb begin
    full    = (sp_q == SP_FULL);
    empty   = (sp_q == '0);
    do_pop  = pop & ~empty;
    do_push = push & ~pop & ~full;
    err     = (pop & empty) | (push & ~pop & full);
    sp_d    = sp_q;
    if (do_pop)
      sp_d = sp_q - SP_ONE;
    else if (do_push)
      sp_d = sp_q + SP_ONE;
  end

  // When full the pointer's low bits wrap to 0, so minus one still lands on the last slot.
  always_comb begin
    top_idx = sp_q[PW-1:0] - IDX_ONE;
    top     = mem_q[top_idx];
    count   = sp_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sp_q <= '0;
    else
      sp_q <= sp_d;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[sp_q[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with edge-triggered increment, relative branch, and call/return stack.
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned CS_W        = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CS_W-1:0]                control_signal,
  input  logic [ADDR_W-1:0]              data_from_mbr,
  output logic [ADDR_W-1:0]              data_to_mbr,
  output logic [ADDR_W-1:0]              data_to_mar,
  output logic [ADDR_W-1:0]              pc_value,
  output logic [$clog2(STACK_DEPTH):0]   stk_count,
  output logic                           stk_full,
  output logic                           stk_empty,
  output logic                           stk_err
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mbr_q, mar_q;
  logic              inc_prev_q;
  logic              err_q, err_d;
  logic              inc_edge;
  logic [ADDR_W-1:0] pc_plus1;
  pc_sel_e           sel;

  logic              stk_push, stk_pop, stk_err_pulse;
  logic [ADDR_W-1:0] stk_top;

  ras_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_plus1),
    .top       (stk_top),
    .count     (stk_count),
    .full      (stk_full),
    .empty     (stk_empty),
    .err       (stk_err_pulse)
  );

  always_comb begin
    inc_edge = control_signal[CS_PC_INC] & ~inc_prev_q;
    pc_plus1 = pc_q + PC_ONE;

    sel = PC_HOLD;
    if (control_signal[CS_RET])
      sel = PC_RET;
    else if (control_signal[CS_CALL])
      sel = PC_CALL;
    else if (control_signal[CS_MBR_TO_PC])
      sel = PC_LOAD;
    else if (control_signal[CS_PC_BR])
      sel = PC_BR;
    else if (inc_edge)
      sel = PC_INC;

    stk_push = (sel == PC_CALL);
    stk_pop  = (sel == PC_RET);

    // Plain addition gives the two's-complement offset result mod 2^ADDR_W.
    unique case (sel)
      PC_RET:  pc_d = stk_empty ? pc_q : stk_top;
      PC_CALL: pc_d = stk_full  ? pc_q : data_from_mbr;
      PC_LOAD: pc_d = data_from_mbr;
      PC_BR:   pc_d = pc_q + data_from_mbr;
      PC_INC:  pc_d = pc_plus1;
      default: pc_d = pc_q;
    endcase

    err_d = err_q;
    if (stk_err_pulse)
      err_d = 1'b1;
    else if (control_signal[CS_CLR_ERR])
      err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= '0;
      mbr_q      <= '0;
      mar_q      <= '0;
      inc_prev_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inc_prev_q <= control_signal[CS_PC_INC];
      err_q      <= err_d;
      if (control_signal[CS_PC_TO_MBR])
        mbr_q <= pc_q;
      if (control_signal[CS_PC_TO_MAR])
        mar_q <= pc_q;
    end
  end

  always_comb begin
    pc_value    = pc_q;
    data_to_mbr = mbr_q;
    data_to_mar = mar_q;
    stk_err     = err_q;
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: scripted scenarios plus randomized traffic vs. a queue model.
module tb_pc_stack_unit;

  localparam int B_MBR = 1, B_MAR = 2, B_LD = 3, B_INC = 20, B_BR = 21,
                 B_CALL = 22, B_RET = 23, B_CLR = 24;

  logic        clk;
  logic        rst;
  logic [31:0] control_signal;
  logic [7:0]  data_from_mbr;
  logic [7:0]  data_to_mbr, data_to_mar, pc_value;
  logic [2:0]  stk_count;
  logic        stk_full, stk_empty, stk_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_pc, m_mbr, m_mar;
  bit m_prev, m_err;
  int m_stack[$];

  pc_stack_unit #(
    .ADDR_W      (8),
    .STACK_DEPTH (4),
    .CS_W        (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .control_signal (control_signal),
    .data_from_mbr  (data_from_mbr),
    .data_to_mbr    (data_to_mbr),
    .data_to_mar    (data_to_mar),
    .pc_value       (pc_value),
    .stk_count      (stk_count),
    .stk_full       (stk_full),
    .stk_empty      (stk_empty),
    .stk_err        (stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] bits(input int a, input int b = -1, input int c = -1);
    logic [31:0] v;
    v = '0;
    v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    return v;
  endfunction

  function automatic void model_reset();
    m_pc = 0; m_mbr = 0; m_mar = 0; m_prev = 0; m_err = 0;
    m_stack.delete();
  endfunction

  function automatic void model_step(input logic [31:0] cs, input logic [7:0] d);
    int  old_pc;
    int  off;
    bit  rising, new_err;
    old_pc  = m_pc;
    rising  = cs[B_INC] && !m_prev;
    m_prev  = cs[B_INC];
    new_err = 0;
    off     = (d >= 128) ? int'(d) - 256 : int'(d);
    if (cs[B_RET]) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else new_err = 1;
    end else if (cs[B_CALL]) begin
      if (m_stack.size() < 4) begin
        m_stack.push_back((m_pc + 1) % 256);
        m_pc = d;
      end else new_err = 1;
    end else if (cs[B_LD]) m_pc = d;
    else if (cs[B_BR]) m_pc = (m_pc + off) & 255;
    else if (rising) m_pc = (m_pc + 1) % 256;
    if (cs[B_MBR]) m_mbr = old_pc;
    if (cs[B_MAR]) m_mar = old_pc;
    if (new_err) m_err = 1;
    else if (cs[B_CLR]) m_err = 0;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic drive(input logic [31:0] cs, input logic [7:0] d);
    control_signal = cs;
    data_from_mbr  = d;
    model_step(cs, d);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    control_signal = '0;
    data_from_mbr  = '0;
    model_reset();
    #12;
    n_checks++; if (pc_value !== 8'h00) $display("FAIL reset_pc got %h exp 00", pc_value); else n_pass++;
    n_checks++; if (data_to_mbr !== 8'h00 || data_to_mar !== 8'h00)
      $display("FAIL reset_copy got mbr %h mar %h exp 00 00", data_to_mbr, data_to_mar); else n_pass++;
    n_checks++; if ({stk_count, stk_full, stk_empty, stk_err} !== {3'd0, 1'b0, 1'b1, 1'b0})
      $display("FAIL reset_stack got cnt %0d full %b empty %b err %b exp 0 0 1 0",
               stk_count, stk_full, stk_empty, stk_err); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_increment();
    logic [7:0] exp_pc [5] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02};
    logic [31:0] seq [5];
    seq = '{bits(B_INC), bits(B_INC), bits(B_INC), 32'h0, bits(B_INC)};
    for (int i = 0; i < 5; i++) begin
      drive(seq[i], 8'h00);
      n_checks++;
      if (pc_value !== exp_pc[i]) $display("FAIL increment[%0d] got %h exp %h", i, pc_value, exp_pc[i]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    drive(bits(B_LD), 8'hFE);
    drive(bits(B_INC), 8'h00);
    n_checks++; if (pc_value !== 8'hFF) $display("FAIL wrap_ff got %h exp ff", pc_value); else n_pass++;
    drive(32'h0, 8'h00);
    drive(bits(B_INC), 8'h00);
    n_checks++; if (pc_value !== 8'h00) $display("FAIL wrap_00 got %h exp 00", pc_value); else n_pass++;
    drive(32'h0, 8'h00);
  endtask

  task automatic test_branch();
    drive(bits(B_LD), 8'h10);
    drive(bits(B_BR), 8'hFC);
    n_checks++; if (pc_value !== 8'h0C) $display("FAIL branch_back got %h exp 0c", pc_value); else n_pass++;
    drive(bits(B_BR), 8'h05);
    n_checks++; if (pc_value !== 8'h11) $display("FAIL branch_fwd got %h exp 11", pc_value); else n_pass++;
  endtask

  task automatic test_call_return();
    drive(bits(B_LD), 8'h20);
    drive(bits(B_CALL), 8'h40);
    n_checks++; if (pc_value !== 8'h40 || stk_count !== 3'd1)
      $display("FAIL call got pc %h cnt %0d exp 40 1", pc_value, stk_count); else n_pass++;
    drive(bits(B_RET), 8'h00);
    n_checks++; if (pc_value !== 8'h21 || stk_empty !== 1'b1)
      $display("FAIL return got pc %h empty %b exp 21 1", pc_value, stk_empty); else n_pass++;
  endtask

  task automatic test_overflow_underflow();
    logic [7:0] tgt [5] = '{8'h50, 8'h60, 8'h70, 8'h80, 8'h90};
    logic [7:0] ret [4] = '{8'h71, 8'h61, 8'h51, 8'h22};
    for (int i = 0; i < 5; i++) drive(bits(B_CALL), tgt[i]);
    n_checks++; if ({pc_value, stk_err, stk_full, stk_count} !== {8'h80, 1'b1, 1'b1, 3'd4})
      $display("FAIL overflow got pc %h err %b full %b cnt %0d exp 80 1 1 4",
               pc_value, stk_err, stk_full, stk_count); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive(bits(B_RET), 8'h00);
      n_checks++;
      if (pc_value !== ret[i]) $display("FAIL unwind[%0d] got %h exp %h", i, pc_value, ret[i]);
      else n_pass++;
    end
    drive(bits(B_RET), 8'h00);
    n_checks++; if (pc_value !== 8'h22 || stk_err !== 1'b1 || stk_empty !== 1'b1)
      $display("FAIL underflow got pc %h err %b empty %b exp 22 1 1", pc_value, stk_err, stk_empty); else n_pass++;
    drive(bits(B_CLR), 8'h00);
    n_checks++; if (stk_err !== 1'b0) $display("FAIL clr_err got %b exp 0", stk_err); else n_pass++;
    drive(bits(B_RET, B_CLR), 8'h00);
    n_checks++; if (stk_err !== 1'b1) $display("FAIL err_beats_clr got %b exp 1", stk_err); else n_pass++;
    drive(bits(B_CLR), 8'h00);
  endtask

  task automatic test_combo_and_async_reset();
    drive(bits(B_LD), 8'h07);
    drive(32'h0, 8'h00);
    drive(bits(B_LD, B_INC, B_MAR), 8'h33);
    n_checks++; if (pc_value !== 8'h33 || data_to_mar !== 8'h07)
      $display("FAIL combo got pc %h mar %h exp 33 07", pc_value, data_to_mar); else n_pass++;
    drive(bits(B_CALL, B_MBR), 8'h99);
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if ({pc_value, data_to_mbr, data_to_mar, stk_count, stk_err} !== '0 || stk_empty !== 1'b1)
      $display("FAIL async_reset got pc %h mbr %h mar %h cnt %0d err %b empty %b exp all 0 empty 1",
               pc_value, data_to_mbr, data_to_mar, stk_count, stk_err, stk_empty); else n_pass++;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] cs;
    logic [7:0]  d;
    for (int i = 0; i < 300; i++) begin
      cs = '0;
      cs[B_MBR]  = ($urandom_range(0, 3) == 0);
      cs[B_MAR]  = ($urandom_range(0, 3) == 0);
      cs[B_LD]   = ($urandom_range(0, 7) == 0);
      cs[B_INC]  = ($urandom_range(0, 1) == 0);
      cs[B_BR]   = ($urandom_range(0, 7) == 0);
      cs[B_CALL] = ($urandom_range(0, 3) == 0);
      cs[B_RET]  = ($urandom_range(0, 4) == 0);
      cs[B_CLR]  = ($urandom_range(0, 9) == 0);
      d = 8'($urandom);
      drive(cs, d);
      n_checks++;
      if (pc_value !== 8'(m_pc) || data_to_mbr !== 8'(m_mbr) || data_to_mar !== 8'(m_mar) ||
          stk_count !== 3'(m_stack.size()) || stk_full !== (m_stack.size() == 4) ||
          stk_empty !== (m_stack.size() == 0) || stk_err !== m_err)
        $display("FAIL random[%0d] cs %h d %h got pc %h mbr %h mar %h cnt %0d f %b e %b err %b exp pc %h mbr %h mar %h cnt %0d err %b",
                 i, cs, d, pc_value, data_to_mbr, data_to_mar, stk_count, stk_full, stk_empty, stk_err,
                 8'(m_pc), 8'(m_mbr), 8'(m_mar), m_stack.size(), m_err);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_wrap();
    test_branch();
    test_call_return();
    test_overflow_underflow();
    test_combo_and_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program counter for the microprogrammed CPU datapath, driven by the shared control word and exchanging values with the MBR and MAR. It extends the basic PC (load, increment, copy-out) with a clean synchronous increment strobe, PC-relative branching, and a hardware return-address stack (call/return) with overflow/underflow detection. It sits between the control unit (control word source) and the MBR/MAR registers.

## Interface
- ADDR_W, 8: width of PC, MBR data and MAR address paths.
- STACK_DEPTH, 4: number of return-address entries; power of two, ≥2.
- CS_W, 32: control word width; all bit indices used below must be < CS_W.
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- control_signal  in  CS_W  control word from control unit, held stable around clk rising edge.
- data_from_mbr  in  ADDR_W  MBR contents: load target, call target, or signed branch offset.
- data_to_mbr  out  ADDR_W  registered copy of PC for MBR.
- data_to_mar  out  ADDR_W  registered copy of PC for MAR.
- pc_value  out  ADDR_W  current PC (direct from PC register).
- stk_count  out  $clog2(STACK_DEPTH)+1  entries on return-address stack.
- stk_full  out  1  stk_count == STACK_DEPTH.
- stk_empty  out  1  stk_count == 0.
- stk_err  out  1  sticky: call on full or return on empty occurred.

## Operation
- Control bits: 1 PC→MBR, 2 PC→MAR, 3 MBR→PC (load), 20 increment, 21 relative branch, 22 call, 23 return, 24 clear stk_err.
- Increment: fires on a 0→1 transition of bit 20, detected against a registered copy of bit 20 (no clocking on control bits). Holding bit 20 high gives exactly one increment.
- PC→MBR / PC→MAR: output register captures PC value present before this edge's update.
- Load: PC ← data_from_mbr.
- Relative branch: PC ← PC + data_from_mbr interpreted as two's complement; result mod 2^ADDR_W.
- Call: push PC+1 (mod 2^ADDR_W) onto stack, PC ← data_from_mbr. If stack full: no push, PC unchanged, stk_err ← 1.
- Return: PC ← top entry, pop. If stack empty: PC unchanged, stk_err ← 1.
- PC-update priority when several requested in one cycle: return > call > load > relative branch > increment; only the highest takes effect, lower requests dropped (increment edge is consumed, not deferred).
- Copy-outs (bits 1, 2) and bit 24 operate independently of PC-update priority. Bit 24 with a new error in same cycle: error wins (stk_err = 1).
- Increment of all-ones wraps to 0; no flag.

## Timing
- Reset (rst low, async): PC, data_to_mbr, data_to_mar = 0; stack pointer 0 (stk_empty = 1, stk_full = 0); stk_err = 0; edge-detect register = 0 (so bit 20 high at reset release counts as an edge on first clock). Stack entry contents don't-care.
- All PC operations: 1-cycle latency; pc_value reflects update after the same rising edge.
- data_to_mbr/mar: registered, valid after the edge where bit 1/2 sampled high; hold otherwise.
- stk_count/full/empty: combinational from stack pointer, update same edge as push/pop.
- Reset asserted mid-operation aborts everything; no partial push.

## Structure
- Package pc_pkg: control-bit index constants (CS_PC_TO_MBR=1, CS_PC_TO_MAR=2, CS_MBR_TO_PC=3, CS_PC_INC=20, CS_PC_BR=21, CS_CALL=22, CS_RET=23, CS_CLR_ERR=24).
- Sub-module ras_stack (params WIDTH, DEPTH): push/pop, top, count, full, empty; rejects push when full and pop when empty, reports each via an error pulse.
- Top module: edge detect, priority mux, next-PC adder, output registers, sticky error.

## Test plan
- Reset then bit 20 pulsed high 3 cycles, low, high 1 cycle -> pc_value 0→1→2; second pulse gives 2; held high counts once.
- Load 0xFE, two increment edges -> 0xFF then 0x00 (wrap).
- PC=0x10, bit 21 with data 0xFC -> 0x0C; data 0x05 -> 0x11.
- PC=0x20, call to 0x40 -> PC 0x40, stk_count 1; return -> PC 0x21, stk_empty 1.
- Five calls with DEPTH 4 -> 5th ignored, stk_err 1, stk_full 1; four returns unwind correctly; extra return -> PC unchanged; bit 24 clears stk_err.
- Same cycle bits 3, 20, 2 with data 0x33, PC 0x07 -> PC 0x33, data_to_mar 0x07; rst low mid-sequence -> all outputs 0 immediately.
